// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table checker: FSM state encoding and
// expected-Y masks of the lab's truth-table modules (bit i = Y for vector i).
package tt_pkg;

    localparam int unsigned MAX_IN     = 4;
    localparam int unsigned VEC_W      = MAX_IN;
    localparam int unsigned ERR_W      = 5;
    localparam int unsigned MASK_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } tt_state_e;

    // tabla_1 is a 3-input table; only the low 8 bits are meaningful
    localparam logic [MASK_W-1:0] TABLA_1 = 16'h00AF;
    // tabla_4: Y = (~B & ~D) | (A & C) | (A & B)
    localparam logic [MASK_W-1:0] TABLA_4 = 16'hFD05;

endpackage : tt_pkg

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times how long each vector is held before sampling.
module tt_settle_timer #(
    parameter int unsigned CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          dec_i,
    input  logic [CW-1:0] load_val_i,
    output logic          zero_c_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c_o = (cnt_q == '0);

endmodule : tt_settle_timer

// File: rtl/truth_table_checker.sv
// Exhaustive sweeper for an A..D -> Y combinational DUT: drives every vector,
// samples Y after a settle time and reports pass, mismatch count and first failure.
module truth_table_checker
    import tt_pkg::*;
#(
    parameter int unsigned       N_IN     = 4,
    parameter int unsigned       SETTLE   = 2,
    parameter logic [MASK_W-1:0] EXPECTED = TABLA_4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [VEC_W-1:0] dut_in,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [VEC_W-1:0] first_fail
);

    localparam int unsigned CW = $clog2(SETTLE) + 1;
    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] IDX_LAST    = '1;

    if (SETTLE < 1) begin : g_bad_settle
        $error("truth_table_checker: SETTLE must be at least 1");
    end
    if ((N_IN < 1) || (N_IN > MAX_IN)) begin : g_bad_n_in
        $error("truth_table_checker: N_IN must be in 1..4");
    end

    tt_state_e        state_q, state_d;
    logic [N_IN-1:0]  idx_q, idx_d;
    logic [VEC_W-1:0] dut_in_q, dut_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             fail_valid_q, fail_valid_d;
    logic [VEC_W-1:0] first_fail_q, first_fail_d;

    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_zero_c;
    logic             mismatch_c;

    tt_settle_timer #(
        .CW (CW)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .dec_i      (tmr_dec),
        .load_val_i (SETTLE_LOAD),
        .zero_c_o   (tmr_zero_c)
    );

    // Case inequality so an X/Z on dut_y is scored as a mismatch in simulation
    assign mismatch_c = (dut_y !== EXPECTED[VEC_W'(idx_q)]);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dut_in_d     = dut_in_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_count_d  = err_count_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_APPLY;
                    idx_d        = '0;
                    dut_in_d     = '0;
                    tmr_load     = 1'b1;
                    err_count_d  = '0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                    pass_d       = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            ST_APPLY: begin
                if (tmr_zero_c) begin
                    state_d = ST_SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch_c) begin
                    err_count_d = err_count_q + ERR_W'(1);
                    if (!fail_valid_q) begin
                        first_fail_d = VEC_W'(idx_q);
                        fail_valid_d = 1'b1;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d    = idx_q + N_IN'(1);
                    dut_in_d = VEC_W'(idx_q + N_IN'(1));
                    tmr_load = 1'b1;
                    state_d  = ST_APPLY;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_count_q == '0);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            dut_in_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dut_in_q     <= dut_in_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign dut_in     = dut_in_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign fail_valid = fail_valid_q;
    assign first_fail = first_fail_q;

endmodule : truth_table_checker

// File: tb/tb_truth_table_checker.sv
// Directed bench: default 4-input/SETTLE=2 checker against tabla_4 models, plus a
// 3-input/SETTLE=1 instance against a tabla_1 model.
module tb_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start3;
    logic [3:0] dut_in4, dut_in3;
    logic       y4, y3;
    logic       busy4, busy3, done4, done3, pass4, pass3, fv4, fv3;
    logic [4:0] err4, err3;
    logic [3:0] ff4, ff3;

    int         mode;
    bit         cur3;
    int         n_tests = 0;
    int         n_fail  = 0;

    logic       o_busy, o_done, o_pass, o_fv;
    logic [4:0] o_err;
    logic [3:0] o_ff, o_dut_in;

    always #5 clk = ~clk;

    truth_table_checker u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .dut_in(dut_in4), .dut_y(y4),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
        .fail_valid(fv4), .first_fail(ff4)
    );

    truth_table_checker #(.N_IN(3), .SETTLE(1), .EXPECTED(16'h00AF)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .dut_in(dut_in3), .dut_y(y3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_valid(fv3), .first_fail(ff3)
    );

    // tabla_4 model (A=bit3 .. D=bit0); mode 1 corrupts vector 6, mode 2 inverts all
    always_comb begin
        logic a, b, c, d, y;
        a = dut_in4[3]; b = dut_in4[2]; c = dut_in4[1]; d = dut_in4[0];
        y = (~b & ~d) | (a & c) | (a & b);
        if (mode == 1 && dut_in4 == 4'd6) y = ~y;
        if (mode == 2) y = ~y;
        y4 = y;
    end

    // tabla_1 model: Y = ~A | C with A=bit2, C=bit0
    assign y3 = ~dut_in3[2] | dut_in3[0];

    always_comb begin
        o_busy   = cur3 ? busy3   : busy4;
        o_done   = cur3 ? done3   : done4;
        o_pass   = cur3 ? pass3   : pass4;
        o_fv     = cur3 ? fv3     : fv4;
        o_err    = cur3 ? err3    : err4;
        o_ff     = cur3 ? ff3     : ff4;
        o_dut_in = cur3 ? dut_in3 : dut_in4;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch a sweep, track dut_in every cycle and return cycles from accept to done
    task automatic run_sweep(input bit s3, input bit inject, output int cyc);
        int  hold;
        int  last;
        int  exp_in;
        bit  seen;
        hold = s3 ? 2 : 3;
        last = s3 ? 7 : 15;
        cur3 = s3;
        @(negedge clk);
        if (s3) start3 = 1'b1; else start4 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0; start4 = 1'b0;
        check("busy_after_accept", 32'(o_busy), 32'd1);
        check("dut_in_after_accept", 32'(o_dut_in), 32'd0);
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 200 && !seen) begin
            @(posedge clk); #1;
            cyc++;
            start4 = (!s3 && inject && (cyc == 9 || cyc == 29)) ? 1'b1 : 1'b0;
            exp_in = (cyc / hold > last) ? last : cyc / hold;
            check("dut_in_step", 32'(o_dut_in), 32'(exp_in));
            if (o_done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("busy_at_done", 32'(o_busy), 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(o_done), 32'd0);
        check("dut_in_kept", 32'(o_dut_in), 32'(last));
    endtask

    initial begin
        int  cyc;
        bit  saw_done;
        rst = 1'b1; start4 = 1'b0; start3 = 1'b0; mode = 0; cur3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dut_in", 32'(dut_in4), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_done", 32'(done4), 32'd0);
        check("rst_pass", 32'(pass4), 32'd0);
        check("rst_err", 32'(err4), 32'd0);
        check("rst_fv", 32'(fv4), 32'd0);
        check("rst_ff", 32'(ff4), 32'd0);
        check("rst_busy3", 32'(busy3), 32'd0);
        @(negedge clk); rst = 1'b0;

        // correct tabla_4
        mode = 0;
        run_sweep(1'b0, 1'b0, cyc);
        check("good_latency", 32'(cyc), 32'd49);
        check("good_pass", 32'(pass4), 32'd1);
        check("good_err", 32'(err4), 32'd0);
        check("good_fv", 32'(fv4), 32'd0);

        // vector 6 corrupted
        mode = 1;
        run_sweep(1'b0, 1'b0, cyc);
        check("v6_latency", 32'(cyc), 32'd49);
        check("v6_pass", 32'(pass4), 32'd0);
        check("v6_err", 32'(err4), 32'd1);
        check("v6_ff", 32'(ff4), 32'd6);
        check("v6_fv", 32'(fv4), 32'd1);

        // fully inverted
        mode = 2;
        run_sweep(1'b0, 1'b0, cyc);
        check("inv_err", 32'(err4), 32'd16);
        check("inv_ff", 32'(ff4), 32'd0);
        check("inv_pass", 32'(pass4), 32'd0);
        check("inv_fv", 32'(fv4), 32'd1);

        // start pulses while busy are ignored
        mode = 0;
        run_sweep(1'b0, 1'b1, cyc);
        check("ign_latency", 32'(cyc), 32'd49);
        check("ign_pass", 32'(pass4), 32'd1);
        check("ign_err", 32'(err4), 32'd0);
        check("ign_busy_after", 32'(busy4), 32'd0);

        // reset mid-sweep
        mode = 2;
        cur3 = 1'b0;
        @(negedge clk); start4 = 1'b1;
        @(posedge clk); #1; start4 = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("pre_rst_err_nonzero", 32'(err4 != 5'd0), 32'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check("mid_rst_busy", 32'(busy4), 32'd0);
        check("mid_rst_dut_in", 32'(dut_in4), 32'd0);
        check("mid_rst_err", 32'(err4), 32'd0);
        check("mid_rst_fv", 32'(fv4), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done4 || busy4) saw_done = 1'b1;
        end
        check("mid_rst_no_done", 32'(saw_done), 32'd0);
        mode = 0;
        run_sweep(1'b0, 1'b0, cyc);
        check("post_rst_latency", 32'(cyc), 32'd49);
        check("post_rst_pass", 32'(pass4), 32'd1);

        // 3-input, SETTLE=1 instance
        run_sweep(1'b1, 1'b0, cyc);
        check("n3_latency", 32'(cyc), 32'd17);
        check("n3_pass", 32'(pass3), 32'd1);
        check("n3_err", 32'(err3), 32'd0);
        check("n3_fv", 32'(fv3), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_truth_table_checker
